// File: rtl/qsn_shift_scheduler.sv
// qsn_shift_scheduler: per-layer circulant shift issue scheduler for the 85-bit QSN permutation network
//   sys_clk, rstn            : clock, asynchronous active-low reset
//   layer_start, layer_id    : start pulse and layer to run (ignored while busy)
//   cfg_we/addr/shift/active : table write port, addr = layer*COL_NUM + col (ignored while busy)
//   stall_in                 : holds column issue for the current cycle
//   shift_factor, shift_en, col_id : issue to the permutation network
//   out_valid, out_col_id    : issue delayed by NET_LATENCY, aligned with bs_out
//   busy, layer_done         : layer in progress, single-cycle completion pulse
//   Optional macro SHIFT_REVERSE_EN: issue the inverse rotation (CHECK_PARALLELISM - stored) mod CHECK_PARALLELISM.
module qsn_shift_scheduler #(
    parameter int CHECK_PARALLELISM = 85,
    parameter int SHIFT_WIDTH       = 7,
    parameter int COL_NUM           = 8,
    parameter int LAYER_NUM         = 4,
    parameter int NET_LATENCY       = 2
) (
    input  logic                                 sys_clk,
    input  logic                                 rstn,
    input  logic                                 layer_start,
    input  logic [$clog2(LAYER_NUM)-1:0]         layer_id,
    input  logic                                 cfg_we,
    input  logic [$clog2(LAYER_NUM*COL_NUM)-1:0] cfg_addr,
    input  logic [SHIFT_WIDTH-1:0]               cfg_shift,
    input  logic                                 cfg_active,
    input  logic                                 stall_in,
    output logic [SHIFT_WIDTH-1:0]               shift_factor,
    output logic                                 shift_en,
    output logic [$clog2(COL_NUM)-1:0]           col_id,
    output logic                                 out_valid,
    output logic [$clog2(COL_NUM)-1:0]           out_col_id,
    output logic                                 busy,
    output logic                                 layer_done
);
    localparam int LW    = $clog2(LAYER_NUM);
    localparam int CW    = $clog2(COL_NUM);
    localparam int AW    = $clog2(LAYER_NUM*COL_NUM);
    localparam int DEPTH = LAYER_NUM*COL_NUM;
    localparam logic [SHIFT_WIDTH-1:0] CP = SHIFT_WIDTH'(CHECK_PARALLELISM);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                 state;
    logic [LW-1:0]          lay;
    logic [CW-1:0]          col;
    logic [SHIFT_WIDTH-1:0] tbl_shift [DEPTH];
    logic [DEPTH-1:0]       tbl_act;
    logic [AW-1:0]          idx;
    logic [SHIFT_WIDTH-1:0] stored;
    logic [SHIFT_WIDTH-1:0] issued;
    logic [SHIFT_WIDTH-1:0] wr_shift;
    logic                   issue;
    logic                   pend;
    logic [NET_LATENCY-1:0] pv;
    logic [CW-1:0]          pc [NET_LATENCY];

    // The issue path is a table lookup on registered state; stall_in gates it in the same cycle.
    always_comb begin
        idx          = AW'(lay) * AW'(COL_NUM) + AW'(col);
        stored       = tbl_shift[idx];
        wr_shift     = cfg_shift >= CP ? cfg_shift - CP : cfg_shift;
`ifdef SHIFT_REVERSE_EN
        issued       = stored == '0 ? '0 : CP - stored;
`else
        issued       = stored;
`endif
        issue        = state == ISSUE && !stall_in;
        shift_en     = issue && tbl_act[idx];
        shift_factor = shift_en ? issued : '0;
        col_id       = shift_en ? col : '0;
        // Last stage is excluded: it empties on the same edge that moves DRAIN to DONE.
        pend         = 1'b0;
        for (int i = 0; i < NET_LATENCY-1; i++) pend = pend | pv[i];
    end

    assign out_valid  = pv[NET_LATENCY-1];
    assign out_col_id = pc[NET_LATENCY-1];

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            lay        <= '0;
            col        <= '0;
            busy       <= 1'b0;
            layer_done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (layer_start) begin
                    lay   <= layer_id;
                    col   <= '0;
                    busy  <= 1'b1;
                    state <= ISSUE;
                end
                ISSUE: if (issue) begin
                    if (col == CW'(COL_NUM-1)) state <= DRAIN;
                    else col <= col + 1'b1;
                end
                DRAIN: if (!pend) begin
                    state      <= DONE;
                    layer_done <= 1'b1;
                end
                DONE: begin
                    layer_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) tbl_shift[i] <= '0;
            tbl_act <= '0;
        end else if (cfg_we && !busy) begin
            tbl_shift[cfg_addr] <= wr_shift;
            tbl_act[cfg_addr]   <= cfg_active;
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            pv <= '0;
            for (int i = 0; i < NET_LATENCY; i++) pc[i] <= '0;
        end else begin
            pv[0] <= shift_en;
            pc[0] <= col_id;
            for (int i = 1; i < NET_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                pc[i] <= pc[i-1];
            end
        end
    end
endmodule
